excl_grant_sequencer: RTL
=========================

Name: excl_grant_sequencer

Overview:
- Generates the three mutually exclusive event strobes that the exclusivity monitor checks: at most one of grant_o[2:0] is high in any cycle.
- Sits between three local requesters and a shared single-owner resource, such as a bus port or debug channel, in the E21 testbench/integration layer.
- Round-robin arbitration; a grant is held until the owner signals done.
- A watchdog force-releases a stuck owner and flags the timeout.

Parameters:
- N_REQ, 3, number of requesters; fixed at 3 for the monitor pairing, kept as a parameter for reuse.
- MAX_HOLD, 64, maximum cycles a grant may be held before forced release (≥2).
- HOLD_W, $clog2(MAX_HOLD+1), hold-counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- req_i  in  N_REQ  request level per requester; held high until granted.
- done_i  in  N_REQ  owner release pulse; only the bit of the current owner is honoured.
- bypass_i  in  1  when high, no new grant is issued (same role as the monitor's override input); an active grant continues.
- grant_o  out  N_REQ  one-hot-or-zero ownership strobe, driven from a register.
- busy_o  out  1  OR-reduction of grant_o.
- owner_o  out  2  encoded index of the current owner; 0 when idle.
- timeout_o  out  1  one-cycle pulse on forced release.
- hold_cnt_o  out  HOLD_W  cycles the current grant has been held.

Behaviour:
- Reset, sampled at the clock edge while reset_n=0:
  - grant_o=0, busy_o=0, owner_o=0, timeout_o=0, hold_cnt_o=0.
  - Round-robin pointer rr_ptr=0, so requester 0 has highest priority first.
  - Reset asserted mid-grant drops the grant on that edge; there is no drain.
- FSM states:
  - IDLE: no grant.
  - GRANT: owner holds the resource.
  - RELEASE: one mandatory idle cycle after any release.
- IDLE → GRANT:
  - Condition: |req_i and !bypass_i.
  - Winner: the first set bit of req_i scanning from rr_ptr upward, with wrap-around.
  - grant_o[winner] and owner_o=winner are registered, so the grant is visible 1 cycle after the request is sampled.
  - hold_cnt is set to 1.
- GRANT → RELEASE on done_i[owner]=1:
  - grant_o clears on the next edge.
  - rr_ptr becomes (owner+1) mod N_REQ.
  - done_i bits for non-owners are ignored.
- GRANT → RELEASE on watchdog expiry (hold_cnt==MAX_HOLD and no done):
  - Grant is cleared and timeout_o pulses for exactly 1 cycle.
  - rr_ptr advances as for a normal release.
- done_i[owner] and expiry in the same cycle: treated as a normal release; timeout_o stays 0.
- In GRANT, hold_cnt increments each cycle and saturates at MAX_HOLD.
- RELEASE → IDLE unconditionally; grant_o=0 in RELEASE. This guarantees a zero cycle between owners.
- bypass_i rising during GRANT does not affect the current owner. It only blocks the next IDLE → GRANT.
- A requester dropping req_i while granted does not release the grant; only done_i or the watchdog does.
- Invariant, checked by an internal assertion under `ifndef SYNTHESIS: $onehot0(grant_o) every cycle once reset_n=1.
- Output consistency: busy_o==|grant_o, and owner_o matches grant_o whenever busy_o=1.

Decomposition:
- Shared package excl_grant_pkg:
  - State enum: IDLE, GRANT, RELEASE.
  - Localparam N_REQ_DEFAULT=3.
  - Function rr_pick(req, ptr), returning the encoded winner.
- Natural sub-module: rr_pick_comb, a purely combinational rotate-priority-encoder.
- The top module holds the FSM, the rr_ptr register, the hold counter and the output registers.

Test Plan:
- Reset and basic grant: hold reset_n=0 for 3 cycles, then set req_i=3'b010. Required: grant_o=3'b010 and owner_o=1 on the 2nd edge after release. Then pulse done_i=3'b010. Required: grant_o=0 for ≥1 cycle (RELEASE), and rr_ptr→2.
- Round-robin fairness: keep req_i=3'b111, with each owner pulsing done 2 cycles after its grant. Required: grant sequence 001, 010, 100, 001, with a 0 cycle between each, and $onehot0 never violated.
- Watchdog: MAX_HOLD=4, req_i=3'b100, done_i held 0. Required:
  - hold_cnt_o counts 1, 2, 3, 4.
  - On the next edge grant_o=0 and timeout_o=1 for exactly 1 cycle.
  - The next grant goes to requester 0 when req_i=3'b101.
- Simultaneous done and expiry: MAX_HOLD=4, done_i[owner] pulsed in the cycle with hold_cnt==4. Required: release with timeout_o=0.
- bypass_i:
  - Assert during GRANT. Required: the owner keeps the grant until done.
  - Then, with req_i=3'b011 pending and bypass_i=1. Required: grant_o stays 0.
  - Deassert bypass_i. Required: grant issued 1 cycle later.
- Reset mid-grant and foreign done: during GRANT of requester 1, pulse done_i=3'b001. Required: ignored, grant held. Then drive reset_n=0 for 1 cycle. Required: all outputs 0 and rr_ptr=0 on that edge.

Source files
------------

// File: rtl/excl_grant_pkg.sv
// Shared types and the round-robin pick function for the exclusive grant sequencer.
package excl_grant_pkg;

  localparam int unsigned N_REQ_DEFAULT = 3;
  // Widest request vector rr_pick handles; owner indices are 2 bits.
  localparam int unsigned REQ_MAX = 4;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRelease
  } state_e;

  // First set bit of req at or above ptr, wrapping modulo n. Returns 0 if req is empty.
  function automatic logic [1:0] rr_pick(logic [REQ_MAX-1:0] req, logic [1:0] ptr,
                                         int unsigned n);
    logic [1:0]  win;
    logic        found;
    int unsigned idx;
    logic [1:0]  idx2;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < REQ_MAX; i++) begin
      idx  = (32'(ptr) + i) % n;
      idx2 = idx[1:0];
      if (i < n && !found && req[idx2]) begin
        win   = idx2;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational rotate-priority encoder: picks the first requester at or after the pointer.
module rr_pick_comb
  import excl_grant_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [1:0]       winner_o
);

  always_comb begin
    winner_o = rr_pick(REQ_MAX'(req_i), ptr_i, N_REQ);
  end

endmodule

// File: rtl/excl_grant_sequencer.sv
// Round-robin single-owner arbiter with hold watchdog; grants are one-hot-or-zero and
// always separated by at least one idle cycle.
module excl_grant_sequencer
  import excl_grant_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEFAULT,
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_REQ-1:0]  req_i,
  input  logic [N_REQ-1:0]  done_i,
  input  logic              bypass_i,
  output logic [N_REQ-1:0]  grant_o,
  output logic              busy_o,
  output logic [1:0]        owner_o,
  output logic              timeout_o,
  output logic [HOLD_W-1:0] hold_cnt_o
);

  localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(MAX_HOLD);
  localparam logic [1:0]        LastReq = 2'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               timeout_q, timeout_d;
  logic [1:0]         winner;
  logic               owner_done;

  rr_pick_comb #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .winner_o(winner)
  );

  assign owner_done = done_i[owner_q];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_i && !bypass_i) begin
          state_d         = StGrant;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          owner_d         = winner;
          hold_d          = HOLD_W'(1);
        end
      end
      StGrant: begin
        if (owner_done || hold_q == HoldMax) begin
          state_d   = StRelease;
          grant_d   = '0;
          owner_d   = '0;
          hold_d    = '0;
          rr_ptr_d  = (owner_q == LastReq) ? 2'd0 : owner_q + 2'd1;
          // A done arriving on the expiry cycle wins: normal release, no timeout.
          timeout_d = !owner_done;
        end else begin
          // Expiry releases at HoldMax, so the counter never passes it.
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o    = grant_q;
  assign busy_o     = |grant_q;
  assign owner_o    = owner_q;
  assign timeout_o  = timeout_q;
  assign hold_cnt_o = hold_q;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert ($onehot0(grant_q)) else $error("grant_o not onehot0: %b", grant_q);
    end
  end
`endif

endmodule
